// File: rtl/gf_pkg.sv
// Shared GF(2^8) types and constants for the multiply scheduler.
package gf_pkg;

  localparam logic [8:0]  GF_POLY  = 9'h11D;
  localparam int unsigned GF_ORDER = 255;

  typedef logic [7:0] gf_elem_t;
  typedef logic [7:0] gf_log_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOG_A,
    S_LOG_B,
    S_EXP,
    S_RESP
  } gf_sched_state_e;

endpackage

// File: rtl/gf_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module gf_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = (32'(ptr_i) + i) % N_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/gf_mul_sched.sv
// Time-shares one external log LUT and one antilog LUT between N_REQ GF(2^8) multiply clients.
module gf_mul_sched
  import gf_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ-1:0][7:0] req_a_i,
  input  logic [N_REQ-1:0][7:0] req_b_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [7:0]            resp_data_o,
  output logic [7:0]            log_addr_o,
  input  logic [7:0]            log_data_i,
  output logic [7:0]            exp_addr_o,
  input  logic [7:0]            exp_data_i
);

  localparam logic [8:0] ORDER9 = 9'(GF_ORDER);

  gf_sched_state_e state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  gf_elem_t        a_q, b_q, data_q;
  gf_log_t         la_q, lb_q;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  win_idx;
  logic             win_any;
  gf_elem_t         win_a, win_b;
  logic             win_zero;
  logic [8:0]       sum_raw, sum_mod;

  gf_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign win_a    = req_a_i[win_idx];
  assign win_b    = req_b_i[win_idx];
  assign win_zero = (win_a == '0) || (win_b == '0);

  // Exponent sum reduced mod 255 so the antilog address stays within 0..254.
  assign sum_raw = {1'b0, la_q} + {1'b0, lb_q};
  assign sum_mod = (sum_raw >= ORDER9) ? (sum_raw - ORDER9) : sum_raw;

  assign resp_id_o   = id_q;
  assign resp_data_o = data_q;

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    resp_valid_o = 1'b0;
    log_addr_o   = '0;
    exp_addr_o   = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = gnt;
        if (win_any) state_d = win_zero ? S_RESP : S_LOG_A;
      end
      S_LOG_A: begin
        log_addr_o = a_q;
        state_d    = S_LOG_B;
      end
      S_LOG_B: begin
        log_addr_o = b_q;
        state_d    = S_EXP;
      end
      S_EXP: begin
        exp_addr_o = sum_mod[7:0];
        state_d    = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      la_q     <= '0;
      lb_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (win_any) begin
            a_q      <= win_a;
            b_q      <= win_b;
            id_q     <= win_idx;
            rr_ptr_q <= (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
            if (win_zero) data_q <= '0;
          end
        end
        S_LOG_A: la_q   <= log_data_i;
        S_LOG_B: lb_q   <= log_data_i;
        S_EXP:   data_q <= exp_data_i;
        default: ;
      endcase
    end
  end

endmodule
